// File: rtl/candy_issue_pkg.sv
// candy_issue_pkg: shared widths and constants for the candy issue stage
package candy_issue_pkg;
    localparam int REG_BUS_W  = 24;
    localparam int ALU_OP_W   = 8;
    localparam int REG_ADDR_W = 3;
    localparam logic [ALU_OP_W-1:0]  EXE_NOP   = '0;
    localparam logic [REG_BUS_W-1:0] ZERO_WORD = '0;
    localparam logic                 RST_ENABLE = 1'b0;
endpackage

// File: rtl/candy_fwd_mux.sv
// candy_fwd_mux: picks the EX-stage result, zero for r0, or the register file word for one operand
module candy_fwd_mux #(
    parameter int DATA_W = 24,
    parameter int REG_AW = 3
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              ex_valid,
    input  logic              ex_wen,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [DATA_W-1:0] operand
);
    logic zero;
    assign zero    = ~|rs;
    assign operand = (ex_valid & ex_wen & (ex_rd == rs) & ~zero) ? alu_res :
                     zero ? '0 : rf_rdata;
endmodule

// File: rtl/candy_issue.sv
// candy_issue: ID/EX issue register feeding candy_alu, with EX forwarding and writeback pairing
module candy_issue
    import candy_issue_pkg::*;
#(
    parameter int DATA_W  = REG_BUS_W,
    parameter int ALUOP_W = ALU_OP_W,
    parameter int REG_AW  = REG_ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               hold_i,
    input  logic               id_valid_i,
    output logic               id_ready_o,
    input  logic [ALUOP_W-1:0] id_aluop_i,
    input  logic [REG_AW-1:0]  id_rs1_i,
    input  logic [REG_AW-1:0]  id_rs2_i,
    input  logic [REG_AW-1:0]  id_rd_i,
    input  logic [DATA_W-1:0]  id_imm_i,
    input  logic               id_use_imm_i,
    input  logic               id_wen_i,
    output logic [REG_AW-1:0]  rf_raddr1_o,
    output logic [REG_AW-1:0]  rf_raddr2_o,
    input  logic [DATA_W-1:0]  rf_rdata1_i,
    input  logic [DATA_W-1:0]  rf_rdata2_i,
    output logic [ALUOP_W-1:0] aluop_o,
    output logic [DATA_W-1:0]  reg1_o,
    output logic [DATA_W-1:0]  reg2_o,
    input  logic [DATA_W-1:0]  alu_res_i,
    output logic               wb_we_o,
    output logic [REG_AW-1:0]  wb_waddr_o,
    output logic [DATA_W-1:0]  wb_wdata_o
);
    logic               valid_q, use_imm_q, wen_q;
    logic [ALUOP_W-1:0] aluop_q;
    logic [REG_AW-1:0]  rs1_q, rs2_q, rd_q, ex_rd;
    logic [DATA_W-1:0]  imm_q, src1, src2;
    logic               ex_valid, ex_wen, fire, accept;

    assign fire       = valid_q & ~hold_i & ~flush_i;
    assign id_ready_o = ~flush_i & (~valid_q | fire);
    assign accept     = id_valid_i & id_ready_o;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            valid_q   <= 1'b0;
            aluop_q   <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
            wen_q     <= 1'b0;
            ex_valid  <= 1'b0;
            ex_wen    <= 1'b0;
            ex_rd     <= '0;
        end else begin
            // flush both kills the held entry and blocks acceptance (via id_ready_o)
            valid_q  <= accept | (valid_q & ~fire & ~flush_i);
            ex_valid <= fire;
            ex_rd    <= rd_q;
            ex_wen   <= wen_q & (rd_q != '0);
            if (accept) begin
                aluop_q   <= id_aluop_i;
                rs1_q     <= id_rs1_i;
                rs2_q     <= id_rs2_i;
                rd_q      <= id_rd_i;
                imm_q     <= id_imm_i;
                use_imm_q <= id_use_imm_i;
                wen_q     <= id_wen_i;
            end
        end
    end

    assign rf_raddr1_o = rs1_q;
    assign rf_raddr2_o = rs2_q;

    candy_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd1 (
        .rs(rs1_q), .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_rd(ex_rd),
        .alu_res(alu_res_i), .rf_rdata(rf_rdata1_i), .operand(src1)
    );
    candy_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd2 (
        .rs(rs2_q), .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_rd(ex_rd),
        .alu_res(alu_res_i), .rf_rdata(rf_rdata2_i), .operand(src2)
    );

    assign aluop_o = fire ? aluop_q : ALUOP_W'(EXE_NOP);
    assign reg1_o  = fire ? src1 : DATA_W'(ZERO_WORD);
    assign reg2_o  = fire ? (use_imm_q ? imm_q : src2) : DATA_W'(ZERO_WORD);

    // ALU output is registered, so the EX tracking regs line up with alu_res_i
    assign wb_we_o    = ex_valid & ex_wen;
    assign wb_waddr_o = ex_rd;
    assign wb_wdata_o = alu_res_i;
endmodule

// File: tb/tb_candy_issue.sv
// tb_candy_issue: random + directed issue traffic scored against an in-order architectural model
module tb_candy_issue;
    localparam int DW = 24, OW = 8, AW = 3;

    logic          clk = 0, rst = 1, flush_i = 0, hold_i = 0, id_valid_i = 0;
    logic          id_use_imm_i = 0, id_wen_i = 0, id_ready_o, wb_we_o;
    logic [OW-1:0] id_aluop_i = 0, aluop_o;
    logic [AW-1:0] id_rs1_i = 0, id_rs2_i = 0, id_rd_i = 0, rf_raddr1_o, rf_raddr2_o, wb_waddr_o;
    logic [DW-1:0] id_imm_i = 0, rf_rdata1_i, rf_rdata2_i, reg1_o, reg2_o, wb_wdata_o;
    logic [DW-1:0] alu_res = 0;

    // r0 holds garbage in the environment regfile: the DUT must never expose it
    logic [DW-1:0] rf   [8] = '{24'hBAD000, 24'h11, 24'd5, 24'd7, 24'h40, 24'h55, 24'h66, 24'h77};
    logic [DW-1:0] arch [8] = '{24'h0,      24'h11, 24'd5, 24'd7, 24'h40, 24'h55, 24'h66, 24'h77};

    typedef struct packed {
        logic [OW-1:0] op; logic [AW-1:0] rs1, rs2, rd; logic [DW-1:0] imm; logic ui, we;
    } ins_t;
    typedef struct { int unsigned due; logic [OW-1:0] op; logic [DW-1:0] a, b; } iss_t;
    typedef struct { int unsigned due; logic [AW-1:0] rd; logic [DW-1:0] d; } wb_t;

    iss_t iss_q[$];
    wb_t  wb_q[$];
    ins_t p;
    logic pv = 0, exp_ready = 1, last_wb = 0;
    logic [AW-1:0] undo_rd;
    logic [DW-1:0] undo_v;
    int unsigned cyc = 0;
    int vectors = 0, errors = 0;

    candy_issue dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .hold_i(hold_i),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o), .id_aluop_i(id_aluop_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i), .id_imm_i(id_imm_i),
        .id_use_imm_i(id_use_imm_i), .id_wen_i(id_wen_i),
        .rf_raddr1_o(rf_raddr1_o), .rf_raddr2_o(rf_raddr2_o),
        .rf_rdata1_i(rf_rdata1_i), .rf_rdata2_i(rf_rdata2_i),
        .aluop_o(aluop_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .alu_res_i(alu_res),
        .wb_we_o(wb_we_o), .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu_f(input logic [OW-1:0] op, input logic [DW-1:0] a, b);
        case (op)
            8'd1: return a + b;
            8'd2: return a - b;
            8'd3: return a ^ b;
            8'd4: return a & b;
            default: return '0;
        endcase
    endfunction

    assign rf_rdata1_i = rf[rf_raddr1_o];
    assign rf_rdata2_i = rf[rf_raddr2_o];
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        alu_res <= alu_f(aluop_o, reg1_o, reg2_o);
        if (wb_we_o) rf[wb_waddr_o] <= wb_wdata_o;
    end

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", n, cyc, act, exp);
        end
    endtask

    // one clock cycle of stimulus; the model executes each instruction in program order when it issues
    task automatic step(input logic v, input logic [OW-1:0] op, input logic [AW-1:0] s1, s2, d,
                        input logic [DW-1:0] imm, input logic ui, we, h, f);
        logic fire, acc;
        logic [DW-1:0] a, b, r;
        id_valid_i = v; id_aluop_i = op; id_rs1_i = s1; id_rs2_i = s2; id_rd_i = d;
        id_imm_i = imm; id_use_imm_i = ui; id_wen_i = we; hold_i = h; flush_i = f;
        exp_ready = !f && (!pv || !h);
        fire = pv && !h && !f;
        last_wb = 0;
        if (fire) begin
            a = arch[p.rs1];
            b = p.ui ? p.imm : arch[p.rs2];
            iss_q.push_back('{cyc, p.op, a, b});
            r = alu_f(p.op, a, b);
            if (p.we && p.rd != 0) begin
                wb_q.push_back('{cyc + 1, p.rd, r});
                undo_rd = p.rd; undo_v = arch[p.rd]; arch[p.rd] = r; last_wb = 1;
            end
        end
        acc = v && exp_ready;
        @(posedge clk);
        if (f) pv = 0;
        else if (acc) begin pv = 1; p = '{op, s1, s2, d, imm, ui, we}; end
        else if (fire) pv = 0;
        #1;
    endtask

    task automatic do_reset();
        rst = 0; id_valid_i = 0; hold_i = 0; flush_i = 0; pv = 0; exp_ready = 1;
        if (last_wb) begin
            arch[undo_rd] = undo_v;
            wb_q.delete(wb_q.size() - 1);
        end
        last_wb = 0;
        @(posedge clk); #1;
        rst = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        iss_t e;
        wb_t w;
        if (!rst) begin
            chk("rst_ready", id_ready_o, 1);
            chk("rst_wb_we", wb_we_o, 0);
            chk("rst_aluop", aluop_o, 0);
            chk("rst_reg1", reg1_o, 0);
            chk("rst_reg2", reg2_o, 0);
        end else begin
            chk("id_ready", id_ready_o, exp_ready);
            if (aluop_o != 0) begin
                if (iss_q.size() == 0) chk("spurious_issue", aluop_o, 0);
                else begin
                    e = iss_q.pop_front();
                    chk("issue_cycle", cyc, e.due);
                    chk("aluop", aluop_o, e.op);
                    chk("reg1", reg1_o, e.a);
                    chk("reg2", reg2_o, e.b);
                end
            end else begin
                chk("idle_reg1", reg1_o, 0);
                chk("idle_reg2", reg2_o, 0);
                if (iss_q.size() != 0 && iss_q[0].due <= cyc) begin
                    e = iss_q.pop_front();
                    chk("missing_issue", aluop_o, e.op);
                end
            end
            if (wb_we_o) begin
                if (wb_q.size() == 0) chk("spurious_wb", wb_we_o, 0);
                else begin
                    w = wb_q.pop_front();
                    chk("wb_cycle", cyc, w.due);
                    chk("wb_waddr", wb_waddr_o, w.rd);
                    chk("wb_wdata", wb_wdata_o, w.d);
                end
            end else if (wb_q.size() != 0 && wb_q[0].due <= cyc) begin
                w = wb_q.pop_front();
                chk("missing_wb", wb_we_o, 1);
            end
        end
    end

    initial begin
        #1 rst = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        // ADD r1=r2+r3 then dependent SUB r4=r1-r2 (forwarded)
        step(1, 1, 2, 3, 1, 0, 0, 1, 0, 0);
        step(1, 2, 1, 2, 4, 0, 0, 1, 0, 0);
        idle(3);
        // ADD r1=r3+r3, hold 3 cycles, SUB r4=r1-r2 reads the written regfile
        step(1, 1, 3, 3, 1, 0, 0, 1, 0, 0);
        step(1, 2, 1, 2, 4, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(3);
        // rd=0 write is dropped; following r0 read is zero, never forwarded
        step(1, 1, 2, 3, 0, 0, 0, 1, 0, 0);
        step(1, 1, 0, 3, 5, 0, 0, 1, 0, 0);
        idle(3);
        // flush with id_valid while holding an entry; earlier ADD still writes back
        step(1, 1, 2, 3, 6, 0, 0, 1, 0, 0);
        step(1, 3, 1, 2, 7, 0, 0, 1, 0, 0);
        step(1, 2, 6, 2, 5, 0, 0, 1, 0, 1);
        idle(3);
        // reset while EX holds an ADD result
        step(1, 1, 2, 3, 1, 0, 0, 1, 0, 0);
        step(1, 2, 1, 2, 4, 0, 0, 1, 0, 0);
        do_reset();
        idle(3);
        step(1, 1, 1, 4, 7, 24'h123, 1, 1, 0, 0);
        idle(3);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            else step($urandom_range(0, 9) < 8, OW'($urandom_range(1, 4)),
                      AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                      DW'($urandom), $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 8,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
        end
        idle(4);
        chk("iss_q_drained", iss_q.size(), 0);
        chk("wb_q_drained", wb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
